// File: rtl/fc_cpu_bus_master.sv
// fc_cpu_bus_master: Famicom cartridge CPU-side bus initiator.
// Generates a free-running M2 and turns each host command into one
// 6502-style read or write cycle. /ROMSEL is ~(A15 & M2), as on the console.
//
// Ports:
//   osc50, m2_rst            - system clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata - one-entry host command buffer
//   rsp_valid, rsp_data      - one-clock read response pulse and held byte
//   m2, romsel, cpu_rw, cpu_addr, cpu_data_out, cpu_data_oe - cartridge edge
//   cpu_data_in              - data bus read back from the cartridge
//   irq, irq_seen            - /IRQ monitor, only with FC_BUS_IRQ_MON_EN
//
// Optional feature macro: FC_BUS_IRQ_MON_EN (synchronised sticky /IRQ flag,
// cleared by accepting a command at $FFFE).
module fc_cpu_bus_master #(
  parameter int unsigned CYCLE_CLKS = 28,
  parameter int unsigned M2_RISE    = 10,
  parameter int unsigned WDATA_ON   = 12,
  parameter int unsigned WDATA_HOLD = 2
) (
  input  logic        osc50,
  input  logic        m2_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in
`ifdef FC_BUS_IRQ_MON_EN
  ,
  input  logic        irq,
  output logic        irq_seen
`endif
);

  localparam int unsigned PW = $clog2(CYCLE_CLKS);
  localparam logic [PW-1:0] PH_LAST = PW'(CYCLE_CLKS - 1);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  buf_state_e    buf_state_q, buf_state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          buf_write_q, buf_write_d;
  logic [15:0]   buf_addr_q, buf_addr_d;
  logic [7:0]    buf_wdata_q, buf_wdata_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          m2_q, m2_d;
  logic          romsel_q, romsel_d;
  logic          a15_q, a15_d;
  logic          cpu_rw_q, cpu_rw_d;
  logic [14:0]   cpu_addr_q, cpu_addr_d;
  logic [7:0]    cpu_data_out_q, cpu_data_out_d;
  logic          cpu_data_oe_q, cpu_data_oe_d;
  logic          rd_act_q, rd_act_d;
  logic          wr_act_q, wr_act_d;
  logic          pend_vld_q, pend_vld_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          accept_c;
  logic          issue_c;

  assign accept_c = cmd_valid & (buf_state_q == BUF_EMPTY);
  assign issue_c  = (phase_q == '0) & (buf_state_q == BUF_FULL);

  // State register
  always_ff @(posedge osc50 or negedge m2_rst) begin
    if (!m2_rst) begin
      buf_state_q    <= BUF_EMPTY;
      phase_q        <= '0;
      buf_write_q    <= 1'b0;
      buf_addr_q     <= '0;
      buf_wdata_q    <= '0;
      cmd_ready_q    <= 1'b1;
      m2_q           <= 1'b0;
      romsel_q       <= 1'b1;
      a15_q          <= 1'b0;
      cpu_rw_q       <= 1'b1;
      cpu_addr_q     <= '0;
      cpu_data_out_q <= '0;
      cpu_data_oe_q  <= 1'b0;
      rd_act_q       <= 1'b0;
      wr_act_q       <= 1'b0;
      pend_vld_q     <= 1'b0;
      pend_data_q    <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
    end else begin
      buf_state_q    <= buf_state_d;
      phase_q        <= phase_d;
      buf_write_q    <= buf_write_d;
      buf_addr_q     <= buf_addr_d;
      buf_wdata_q    <= buf_wdata_d;
      cmd_ready_q    <= cmd_ready_d;
      m2_q           <= m2_d;
      romsel_q       <= romsel_d;
      a15_q          <= a15_d;
      cpu_rw_q       <= cpu_rw_d;
      cpu_addr_q     <= cpu_addr_d;
      cpu_data_out_q <= cpu_data_out_d;
      cpu_data_oe_q  <= cpu_data_oe_d;
      rd_act_q       <= rd_act_d;
      wr_act_q       <= wr_act_d;
      pend_vld_q     <= pend_vld_d;
      pend_data_q    <= pend_data_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    buf_state_d    = buf_state_q;
    buf_write_d    = buf_write_q;
    buf_addr_d     = buf_addr_q;
    buf_wdata_d    = buf_wdata_q;
    a15_d          = a15_q;
    cpu_rw_d       = cpu_rw_q;
    cpu_addr_d     = cpu_addr_q;
    cpu_data_out_d = cpu_data_out_q;
    cpu_data_oe_d  = cpu_data_oe_q;
    rd_act_d       = rd_act_q;
    wr_act_d       = wr_act_q;
    pend_vld_d     = pend_vld_q;
    pend_data_d    = pend_data_q;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = rsp_data_q;
    phase_d        = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);

    case (buf_state_q)
      BUF_EMPTY: begin
        if (cmd_valid) begin
          buf_state_d = BUF_FULL;
          buf_write_d = cmd_write;
          buf_addr_d  = cmd_addr;
          buf_wdata_d = cmd_wdata;
        end
      end
      BUF_FULL: begin
        if (phase_q == '0) buf_state_d = BUF_EMPTY;
      end
    endcase
    cmd_ready_d = (buf_state_d == BUF_EMPTY);

    // Bus cycle boundary: load a buffered command or fall back to idle
    if (phase_q == '0) begin
      if (buf_state_q == BUF_FULL) begin
        a15_d      = buf_addr_q[15];
        cpu_addr_d = buf_addr_q[14:0];
        cpu_rw_d   = ~buf_write_q;
        rd_act_d   = ~buf_write_q;
        wr_act_d   = buf_write_q;
      end else begin
        a15_d    = 1'b0;
        cpu_rw_d = 1'b1;
        rd_act_d = 1'b0;
        wr_act_d = 1'b0;
      end
    end

    // Read data is taken on the last phase and presented on the next phase 0
    if ((phase_q == PH_LAST) && rd_act_q) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = cpu_data_in;
    end

    m2_d     = (phase_d >= PW'(M2_RISE));
    romsel_d = ~(a15_d & m2_d);

    // Write drive window spans into the next cycle's first phases
    if ((phase_d == PW'(WDATA_ON)) && wr_act_d) begin
      cpu_data_oe_d = 1'b1;
    end else if (phase_d == PW'(WDATA_HOLD)) begin
      cpu_data_oe_d = 1'b0;
    end

    // Keep driven write data stable; park the new byte until the hold ends
    if (issue_c) begin
      if (cpu_data_oe_d) begin
        pend_vld_d  = 1'b1;
        pend_data_d = buf_wdata_q;
      end else begin
        cpu_data_out_d = buf_wdata_q;
      end
    end else if (cpu_data_oe_q && !cpu_data_oe_d && pend_vld_q) begin
      cpu_data_out_d = pend_data_q;
      pend_vld_d     = 1'b0;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign m2           = m2_q;
  assign romsel       = romsel_q;
  assign cpu_rw       = cpu_rw_q;
  assign cpu_addr     = cpu_addr_q;
  assign cpu_data_out = cpu_data_out_q;
  assign cpu_data_oe  = cpu_data_oe_q;

`ifdef FC_BUS_IRQ_MON_EN
  logic irq_s1_q, irq_s2_q;
  logic irq_seen_q, irq_seen_d;

  // /IRQ synchroniser and sticky flag; idles deasserted (high) from reset
  always_ff @(posedge osc50 or negedge m2_rst) begin
    if (!m2_rst) begin
      irq_s1_q   <= 1'b1;
      irq_s2_q   <= 1'b1;
      irq_seen_q <= 1'b0;
    end else begin
      irq_s1_q   <= irq;
      irq_s2_q   <= irq_s1_q;
      irq_seen_q <= irq_seen_d;
    end
  end

  // Accepting the $FFFE vector fetch acknowledges the interrupt
  always_comb begin
    irq_seen_d = irq_seen_q;
    if (accept_c && (cmd_addr == 16'hFFFE)) begin
      irq_seen_d = 1'b0;
    end else if (!irq_s2_q) begin
      irq_seen_d = 1'b1;
    end
  end

  assign irq_seen = irq_seen_q;
`endif

endmodule

// File: tb/tb_fc_cpu_bus_master.sv
`timescale 1ns/1ps
module tb_fc_cpu_bus_master;

  localparam int CC = 28;
  localparam int MR = 10;
  localparam int WO = 12;
  localparam int WH = 2;
  localparam int NPER  = 1024;
  localparam int NHIST = 32768;

  logic        osc50 = 1'b0;
  logic        m2_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [7:0]  cmd_wdata = 8'h0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        m2;
  logic        romsel;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in = 8'h0;
`ifdef FC_BUS_IRQ_MON_EN
  logic        irq = 1'b1;
  logic        irq_seen;
`endif

  fc_cpu_bus_master #(
    .CYCLE_CLKS(CC), .M2_RISE(MR), .WDATA_ON(WO), .WDATA_HOLD(WH)
  ) dut (
    .osc50       (osc50),
    .m2_rst      (m2_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .m2          (m2),
    .romsel      (romsel),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_data_out(cpu_data_out),
    .cpu_data_oe (cpu_data_oe),
    .cpu_data_in (cpu_data_in)
`ifdef FC_BUS_IRQ_MON_EN
    ,
    .irq         (irq),
    .irq_seen    (irq_seen)
`endif
  );

  always #10 osc50 = ~osc50;

  // Reference model: the command owning each M2 period, plus bus read-back history
  bit          per_valid [NPER];
  bit          per_write [NPER];
  logic [15:0] per_addr  [NPER];
  logic [7:0]  per_wdata [NPER];
  logic [7:0]  din_hist  [NHIST];
  int          t;
  int          acc_t;
  int          iss_t;
  logic [14:0] last_addr;
  logic [7:0]  last_rsp;
  int          din_fixed = -1;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, act, exp, t);
    end
  endtask

  function automatic bit ready_model();
    return !((t > acc_t) && (t <= iss_t));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NPER; i++) begin
      per_valid[i] = 1'b0;
      per_write[i] = 1'b0;
      per_addr[i]  = 16'h0;
      per_wdata[i] = 8'h0;
    end
    t = 0;
    acc_t = -100;
    iss_t = -100;
    last_addr = 15'h0;
    last_rsp = 8'h0;
  endtask

  // Expected cartridge-edge view for interval t, derived from period ownership
  task automatic check_all();
    int ph, p, pb;
    bit cur_v, cur_w, cur_a15, wr_now, wr_prev, oe_e, rv_e;
    logic [7:0] dout_e;
    ph = t % CC;
    p  = t / CC;
    pb = (ph == 0) ? p - 1 : p;
    if (ph == 1 && per_valid[p]) last_addr = per_addr[p][14:0];
    cur_v = 1'b0; cur_w = 1'b0; cur_a15 = 1'b0;
    if (pb >= 0 && per_valid[pb]) begin
      cur_v   = 1'b1;
      cur_w   = per_write[pb];
      cur_a15 = per_addr[pb][15];
    end
    wr_now  = per_valid[p] && per_write[p];
    wr_prev = (p >= 1) && per_valid[p-1] && per_write[p-1];
    oe_e = ((ph >= WO) && wr_now) || ((ph < WH) && wr_prev);
    dout_e = (ph >= WO) ? per_wdata[p] : ((p >= 1) ? per_wdata[p-1] : 8'h0);
    rv_e = (ph == 0) && (p >= 1) && per_valid[p-1] && !per_write[p-1];
    if (rv_e) last_rsp = din_hist[t-1];

    chk("m2", 32'(m2), 32'(ph >= MR));
    chk("romsel", 32'(romsel), 32'(!(cur_v && cur_a15 && (ph >= MR))));
    chk("cpu_rw", 32'(cpu_rw), 32'(!cur_w));
    chk("cpu_addr", 32'(cpu_addr), 32'(last_addr));
    chk("cpu_data_oe", 32'(cpu_data_oe), 32'(oe_e));
    if (oe_e) chk("cpu_data_out", 32'(cpu_data_out), 32'(dout_e));
    chk("rsp_valid", 32'(rsp_valid), 32'(rv_e));
    chk("rsp_data", 32'(rsp_data), 32'(last_rsp));
    chk("cmd_ready", 32'(cmd_ready), 32'(ready_model()));
  endtask

  // One clock: check outputs, drive inputs, record acceptance in the model
  task automatic step(input bit v, input bit w, input logic [15:0] a, input logic [7:0] d);
    logic [7:0] din;
    int np;
    check_all();
    din = (din_fixed >= 0) ? 8'(din_fixed) : 8'($urandom);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    cpu_data_in = din;
    din_hist[t] = din;
    if (v && ready_model()) begin
      np = t / CC + 1;
      acc_t = t;
      iss_t = CC * np;
      per_valid[np] = 1'b1;
      per_write[np] = w;
      per_addr[np]  = a;
      per_wdata[np] = d;
    end
    @(negedge osc50);
    t++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic send(input bit w, input logic [15:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (!ready_model() && n < 200) begin
      step(1'b0, 1'b0, 16'h0, 8'h0);
      n++;
    end
    chk("send_wait", 32'(n < 200), 32'd1);
    step(1'b1, w, a, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] atab [6];
    logic [15:0] ra;
    int pw;
    atab = '{16'h8000, 16'h5000, 16'hC000, 16'hFFFE, 16'h0000, 16'h7FFF};
    model_reset();

    #5 m2_rst = 1'b0;
    repeat (3) @(negedge osc50);
    chk("rst_m2", 32'(m2), 32'd0);
    chk("rst_romsel", 32'(romsel), 32'd1);
    chk("rst_cpu_rw", 32'(cpu_rw), 32'd1);
    chk("rst_cpu_addr", 32'(cpu_addr), 32'd0);
    chk("rst_data_out", 32'(cpu_data_out), 32'd0);
    chk("rst_data_oe", 32'(cpu_data_oe), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
`ifdef FC_BUS_IRQ_MON_EN
    chk("rst_irq_seen", 32'(irq_seen), 32'd0);
`endif
    m2_rst = 1'b1;
    model_reset();

    idle(60);

    din_fixed = 8'hA5;
    send(1'b0, 16'h8000, 8'h00);
    idle(60);
    chk("read_a5", 32'(rsp_data), 32'h0A5);
    din_fixed = -1;

    send(1'b1, 16'h5000, 8'h1F);
    idle(60);
    send(1'b1, 16'hC000, 8'h47);
    idle(60);

    send(1'b0, 16'h8001, 8'h00);
    send(1'b1, 16'h8002, 8'h00);
    idle(60);

`ifdef FC_BUS_IRQ_MON_EN
    irq = 1'b0;
    idle(3);
    chk("irq_seen_set", 32'(irq_seen), 32'd1);
    irq = 1'b1;
    idle(4);
    chk("irq_seen_sticky", 32'(irq_seen), 32'd1);
    send(1'b0, 16'hFFFE, 8'h00);
    chk("irq_seen_clr", 32'(irq_seen), 32'd0);
    idle(30);
`endif

    for (int i = 0; i < 600; i++) begin
      ra = ($urandom_range(0, 1) == 0) ? atab[$urandom_range(0, 5)] : 16'($urandom);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, ra, 8'($urandom));
    end
    idle(60);

    // Reset mid-write with a second command sitting in the buffer
    send(1'b1, 16'hC000, 8'h5A);
    pw = acc_t / CC + 1;
    send(1'b0, 16'h8000, 8'h00);
    while (t < CC * pw + 15) step(1'b0, 1'b0, 16'h0, 8'h0);
    cmd_valid = 1'b0;
    m2_rst = 1'b0;
    #1;
    chk("midrst_m2", 32'(m2), 32'd0);
    chk("midrst_romsel", 32'(romsel), 32'd1);
    chk("midrst_data_oe", 32'(cpu_data_oe), 32'd0);
    chk("midrst_cpu_rw", 32'(cpu_rw), 32'd1);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge osc50);
    m2_rst = 1'b1;
    model_reset();
    idle(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
